// File: rtl/text_pkg.sv
// Shared state encoding and character codes for the text write controller.
package text_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    EXEC
  } state_t;

  localparam logic [6:0] CHAR_CR     = 7'h0D;
  localparam logic [6:0] CHAR_FF     = 7'h0C;
  localparam logic [6:0] CHAR_BS     = 7'h08;
  localparam logic [6:0] CHAR_DEL    = 7'h7F;
  localparam logic [6:0] CHAR_SPACE  = 7'h20;
  localparam logic [6:0] CHAR_PROMPT = 7'h3E;

endpackage

// File: rtl/text_wr_ctrl.sv
// Byte-to-character-memory write sequencer with cursor tracking and screen clear.
// Optional backspace/delete handling is enabled by defining TEXT_BKSP_EN.
module text_wr_ctrl
  import text_pkg::*;
#(
  parameter int unsigned MEMSIZE = 128,
  parameter int unsigned COLS    = 32,
  parameter logic [6:0]  PROMPT  = CHAR_PROMPT,
  parameter logic [6:0]  FILL    = CHAR_SPACE,
  localparam int unsigned AW     = $clog2(MEMSIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [6:0]    mem_wdata,
  output logic [AW-1:0] cursor,
  output logic          busy
);

  localparam int unsigned   CW   = $clog2(COLS);
  localparam logic [AW-1:0] LAST = AW'(MEMSIZE - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic [6:0]    code;
  logic [AW-1:0] inc_next;
  logic [AW-1:0] cr_next;
  logic          printable;
  logic          unused_rx_msb;

  assign unused_rx_msb = rx_data[7];

  // Address 0 holds the prompt, so cursor arithmetic wraps to 1, never 0.
  always_comb begin
    inc_next  = (cursor == LAST) ? ONE : cursor + ONE;
    cr_next   = ((cursor >> CW) + ONE) << CW;
    if (cr_next == '0) cr_next = ONE;
    printable = (code >= CHAR_SPACE) && (code != CHAR_DEL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      cursor    <= ONE;
      code      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rx_ready  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      mem_we <= 1'b0;
      case (state)
        CLEAR: begin
          mem_we    <= 1'b1;
          mem_addr  <= clr_addr;
          mem_wdata <= (clr_addr == '0) ? PROMPT : FILL;
          clr_addr  <= clr_addr + ONE;
          if (clr_addr == LAST) begin
            state    <= IDLE;
            cursor   <= ONE;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        IDLE: begin
          if (rx_valid && rx_ready) begin
            code     <= rx_data[6:0];
            state    <= EXEC;
            rx_ready <= 1'b0;
          end
        end
        EXEC: begin
          state    <= IDLE;
          rx_ready <= 1'b1;
          if (printable) begin
            mem_we    <= 1'b1;
            mem_addr  <= cursor;
            mem_wdata <= code;
            cursor    <= inc_next;
          end else if (code == CHAR_CR) begin
            cursor <= cr_next;
          end else if (code == CHAR_FF) begin
            state    <= CLEAR;
            clr_addr <= '0;
            rx_ready <= 1'b0;
            busy     <= 1'b1;
          end
`ifdef TEXT_BKSP_EN
          else if ((code == CHAR_BS || code == CHAR_DEL) && cursor != ONE) begin
            mem_we    <= 1'b1;
            mem_addr  <= cursor - ONE;
            mem_wdata <= FILL;
            cursor    <= cursor - ONE;
          end
`else
`endif
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
          rx_ready <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule
